// File: rtl/spart_driver.sv
// spart_driver: SPART bus initiator that programs the baud divisor and echoes received bytes.
// Bus outputs are registered; an access issued from a state appears on the bus the cycle after.
module spart_driver #(
    parameter logic [15:0] DIV_4800  = 16'h0515,
    parameter logic [15:0] DIV_9600  = 16'h028A,
    parameter logic [15:0] DIV_19200 = 16'h0144,
    parameter logic [15:0] DIV_38400 = 16'h00A2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] br_cfg,
    input  logic       rda,
    input  logic       tbr,
    output logic       iocs,
    output logic       iorw,
    output logic [1:0] ioaddr,
    inout  wire  [7:0] databus
);
    typedef enum logic [2:0] {INIT_LO, INIT_HI, IDLE, READ, HOLD, WAIT_TBR, WRITE} state_t;
    state_t      state_q, state_d;
    logic [1:0]  cfg_q, cfg_d, ioaddr_q, ioaddr_d, sel;
    logic        iocs_q, iocs_d, iorw_q, iorw_d;
    logic [7:0]  rx_q, rx_d, dout_q, dout_d;
    logic [15:0] div;
    always_comb begin
        // The low byte uses the live switches (latched here); the high byte must match the latched copy.
        sel      = state_q == INIT_LO ? br_cfg : cfg_q;
        div      = sel == 2'b00 ? DIV_4800 : sel == 2'b01 ? DIV_9600 :
                   sel == 2'b10 ? DIV_19200 : DIV_38400;
        state_d  = state_q;
        cfg_d    = cfg_q;
        iocs_d   = 1'b0;
        iorw_d   = 1'b1;
        ioaddr_d = 2'b00;
        dout_d   = dout_q;
        rx_d     = (iocs_q && iorw_q) ? databus : rx_q;
        case (state_q)
            INIT_LO: begin
                iocs_d   = 1'b1;
                iorw_d   = 1'b0;
                ioaddr_d = 2'b10;
                dout_d   = div[7:0];
                cfg_d    = br_cfg;
                state_d  = INIT_HI;
            end
            INIT_HI: begin
                iocs_d   = 1'b1;
                iorw_d   = 1'b0;
                ioaddr_d = 2'b11;
                dout_d   = div[15:8];
                state_d  = IDLE;
            end
            IDLE:     state_d = br_cfg != cfg_q ? INIT_LO : rda ? READ : IDLE;
            READ: begin
                iocs_d  = 1'b1;
                state_d = HOLD;
            end
            HOLD:     state_d = WAIT_TBR;
            WAIT_TBR: state_d = tbr ? WRITE : WAIT_TBR;
            WRITE: begin
                iocs_d  = 1'b1;
                iorw_d  = 1'b0;
                dout_d  = rx_q;
                state_d = IDLE;
            end
            default:  state_d = INIT_LO;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= INIT_LO;
            cfg_q    <= 2'b00;
            iocs_q   <= 1'b0;
            iorw_q   <= 1'b1;
            ioaddr_q <= 2'b00;
            dout_q   <= 8'h00;
            rx_q     <= 8'h00;
        end else begin
            state_q  <= state_d;
            cfg_q    <= cfg_d;
            iocs_q   <= iocs_d;
            iorw_q   <= iorw_d;
            ioaddr_q <= ioaddr_d;
            dout_q   <= dout_d;
            rx_q     <= rx_d;
        end
    end
    assign iocs    = iocs_q;
    assign iorw    = iorw_q;
    assign ioaddr  = ioaddr_q;
    assign databus = (iocs_q && !iorw_q) ? dout_q : 8'bz;
endmodule

// File: tb/tb_spart_driver.sv
// tb_spart_driver: randomized scoreboard bench for spart_driver.
// The bus is pulled high so an undriven databus reads 8'hFF.
module tb_spart_driver;
    logic       clk = 1'b0, rst = 1'b1, rda = 1'b0, tbr = 1'b1;
    logic [1:0] br_cfg = 2'b01;
    logic [7:0] rx_byte = 8'h00;
    wire        iocs, iorw;
    wire  [1:0] ioaddr;
    tri1  [7:0] databus;
    int         total = 0, bad = 0;

    typedef struct packed {logic rw; logic [1:0] addr; logic [7:0] data;} txn_t;
    txn_t sb[$];
    logic [15:0] divs [4] = '{16'h0515, 16'h028A, 16'h0144, 16'h00A2};

    spart_driver dut (
        .clk(clk), .rst(rst), .br_cfg(br_cfg), .rda(rda), .tbr(tbr),
        .iocs(iocs), .iorw(iorw), .ioaddr(ioaddr), .databus(databus)
    );

    always #5 clk = ~clk;
    assign databus = (iocs && iorw) ? rx_byte : 8'bz;

    function automatic void exp_wr(input logic [1:0] a, input logic [7:0] d);
        sb.push_back({1'b0, a, d});
    endfunction
    function automatic void exp_rd(input logic [7:0] d);
        sb.push_back({1'b1, 2'b00, d});
    endfunction
    function automatic void exp_init(input logic [1:0] c);
        exp_wr(2'b10, divs[c][7:0]);
        exp_wr(2'b11, divs[c][15:8]);
    endfunction

    // Monitor: every strobe must match the head of the scoreboard; idle cycles must show an idle bus.
    always @(negedge clk) begin
        txn_t e;
        logic [10:0] got, want;
        total++;
        if (iocs === 1'b1) begin
            got = {iorw, ioaddr, iorw ? 8'h00 : databus};
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL unexpected_strobe got=%h required=none", got);
            end else begin
                e = sb.pop_front();
                want = {e.rw, e.addr, e.rw ? 8'h00 : e.data};
                if (got !== want) begin
                    bad++;
                    $display("FAIL bus_txn got=%h required=%h", got, want);
                end
            end
        end else if ({iocs, iorw, ioaddr, databus} !== {1'b0, 1'b1, 2'b00, 8'hFF}) begin
            bad++;
            $display("FAIL idle_bus got=%h required=%h", {iocs, iorw, ioaddr, databus}, 12'h4FF);
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h required=%h", nm, got, want);
        end
    endtask

    task automatic wait_strobe(input logic rd, input int bound, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!(iocs === 1'b1 && iorw === rd) && n < bound);
        if (!(iocs === 1'b1 && iorw === rd)) begin
            total++;
            bad++;
            $display("FAIL wait_strobe got=timeout required=%s strobe", rd ? "read" : "write");
        end
    endtask

    task automatic echo(input logic [7:0] b, input int k);
        int n, early;
        rx_byte = b;
        exp_rd(b);
        exp_wr(2'b00, b);
        tbr = (k == 0);
        rda = 1'b1;
        wait_strobe(1'b1, 20, n);
        rda = 1'b0;
        if (k == 0) begin
            wait_strobe(1'b0, 10, n);
            check("echo_latency", n, 3);
        end else begin
            early = 0;
            repeat (k) begin
                tick();
                if (iocs !== 1'b0 || databus !== 8'hFF) early++;
            end
            check("no_write_while_tbr_low", early, 0);
            tbr = 1'b1;
            wait_strobe(1'b0, 10, n);
            check("tbr_to_write", n, 2);
        end
    endtask

    initial begin
        int n;
        logic [1:0] c;
        exp_init(2'b01);
        repeat (3) tick();
        check("reset_bus", {iocs, iorw, ioaddr, databus}, {1'b0, 1'b1, 2'b00, 8'hFF});
        rst = 1'b0;
        wait_strobe(1'b0, 5, n);
        check("first_init_latency", n, 1);
        repeat (10) tick();
        check("init_drain", sb.size(), 0);

        echo(8'h41, 0);
        repeat (3) tick();
        echo(8'h5A, 20);
        repeat (3) tick();

        // Baud change while an echo is waiting for tbr, with a new byte already pending.
        rx_byte = 8'h3C;
        exp_rd(8'h3C);
        exp_wr(2'b00, 8'h3C);
        tbr = 1'b0;
        rda = 1'b1;
        wait_strobe(1'b1, 20, n);
        rda = 1'b0;
        repeat (2) tick();
        br_cfg = 2'b11;
        exp_init(2'b11);
        rx_byte = 8'h77;
        exp_rd(8'h77);
        exp_wr(2'b00, 8'h77);
        rda = 1'b1;
        tbr = 1'b1;
        repeat (3) wait_strobe(1'b0, 10, n);
        wait_strobe(1'b1, 10, n);
        rda = 1'b0;
        wait_strobe(1'b0, 10, n);
        check("cfg_change_order_drain", sb.size(), 0);
        repeat (3) tick();

        // Reset while waiting for tbr: the pending byte must vanish.
        rx_byte = 8'hC3;
        exp_rd(8'hC3);
        exp_wr(2'b00, 8'hC3);
        tbr = 1'b0;
        rda = 1'b1;
        wait_strobe(1'b1, 20, n);
        rda = 1'b0;
        repeat (2) tick();
        rst = 1'b1;
        #1;
        check("rst_async_bus", {iocs, iorw, ioaddr, databus}, {1'b0, 1'b1, 2'b00, 8'hFF});
        sb.delete();
        exp_init(br_cfg);
        tbr = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        repeat (10) tick();
        check("rst_discard_drain", sb.size(), 0);

        repeat (25) begin
            if ($urandom_range(3) == 0) begin
                c = br_cfg + 2'($urandom_range(1, 3));
                br_cfg = c;
                exp_init(c);
            end
            echo(8'($urandom), $urandom_range(0, 4));
            repeat (3) tick();
            check("random_drain", sb.size(), 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
